// File: rtl/seg7_pkg.sv
// Shared types, constants and the hex glyph table for the seven-segment display blocks.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    typedef logic [3:0] nibble_t;
    typedef logic [7:0] seg_t;

    typedef enum logic {
        BLANK,
        DRIVE
    } scan_state_t;

    localparam seg_t SEG_OFF = 8'hFF;

    // Active-low {A,B,C,D,E,F,G} glyphs for 0-9 and A, b, C, d, E, F.
    function automatic logic [6:0] hex7seg(input nibble_t value);
        logic [6:0] pattern;
        case (value)
            4'h0: pattern = 7'b0000001;
            4'h1: pattern = 7'b1001111;
            4'h2: pattern = 7'b0010010;
            4'h3: pattern = 7'b0000110;
            4'h4: pattern = 7'b1001100;
            4'h5: pattern = 7'b0100100;
            4'h6: pattern = 7'b0100000;
            4'h7: pattern = 7'b0001111;
            4'h8: pattern = 7'b0000000;
            4'h9: pattern = 7'b0000100;
            4'hA: pattern = 7'b0001000;
            4'hB: pattern = 7'b1100000;
            4'hC: pattern = 7'b0110001;
            4'hD: pattern = 7'b1000010;
            4'hE: pattern = 7'b0110000;
            default: pattern = 7'b0111000;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low A..G decoder, shared by the display blocks.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  nibble_t    nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex7seg(nibble);
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed 8-digit scan driver: refresh counter, anti-ghost blanking slot, per-digit DP and blank masks.
module seven_seg_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GHOST_CYC   = 100
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] digits,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  blank_mask,
    output seg_t        seg_n,
    output logic [7:0]  anode_n,
    output logic [2:0]  digit_idx,
    output logic        frame_tick
);

    localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GHOST   = CW'(GHOST_CYC);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    scan_state_t   state;
    nibble_t       nibble;
    logic          dp;
    logic          wrap;
    logic [2:0]    next_idx;
    logic [6:0]    glyph;

    hex_to_seg7 u_hex (
        .nibble (nibble),
        .seg    (glyph)
    );

    always_comb begin
        wrap     = (cnt == CNT_MAX);
        cnt_next = wrap ? '0 : cnt + 1'b1;
        next_idx = digit_idx + 3'd1;
    end

    // State tracks cnt >= GHOST_CYC for the counter value it sits beside, so the
    // output registers (one edge behind) see exactly GHOST_CYC dark cycles per slot.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            digit_idx  <= '0;
            state      <= BLANK;
            nibble     <= '0;
            dp         <= 1'b0;
            seg_n      <= SEG_OFF;
            anode_n    <= '1;
            frame_tick <= 1'b0;
        end else if (!en) begin
            seg_n      <= SEG_OFF;
            anode_n    <= '1;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            frame_tick <= wrap && (digit_idx == 3'd7);

            if (wrap) begin
                digit_idx <= next_idx;
                nibble    <= digits[{next_idx, 2'b00} +: 4];
                dp        <= dp_mask[next_idx];
            end

            case (state)
                BLANK:   if (cnt_next == GHOST) state <= DRIVE;
                DRIVE:   if (wrap && (GHOST_CYC != 0)) state <= BLANK;
                default: state <= BLANK;
            endcase

            if ((state == DRIVE) && !blank_mask[digit_idx]) begin
                anode_n <= ~(8'h80 >> digit_idx);
                seg_n   <= {glyph, ~dp};
            end else begin
                anode_n <= '1;
                seg_n   <= SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver against a time-based scan model.
module tb_seven_seg_scan_driver;

    localparam int R  = 8;
    localparam int G  = 2;
    localparam int FR = 8 * R;

    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [31:0] digits = '0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  blank_mask = '0;
    logic [7:0]  seg_n;
    logic [7:0]  anode_n;
    logic [2:0]  digit_idx;
    logic        frame_tick;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int last_tick = -1;
    int n_ticks = 0;
    bit period_on = 0;

    // Reference model: scan position is simply the count of enabled cycles since reset.
    int         m_active;
    logic [3:0] m_nib;
    logic       m_dp;
    logic [7:0] exp_seg;
    logic [7:0] exp_an;
    logic       exp_tick;

    logic [6:0] ref_tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    logic [7:0] exp_order [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    logic [7:0] order_q [$];

    seven_seg_scan_driver #(
        .REFRESH_DIV (R),
        .GHOST_CYC   (G)
    ) dut (
        .CLK        (CLK),
        .rst        (rst),
        .en         (en),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .seg_n      (seg_n),
        .anode_n    (anode_n),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] model_an(int a, logic [7:0] bm);
        int d = (a / R) % 8;
        logic [7:0] r = 8'hFF;
        if ((a % R) >= G && !bm[d]) r[7-d] = 1'b0;
        return r;
    endfunction

    function automatic logic [7:0] model_seg(int a, logic [7:0] bm, logic [3:0] nib, logic dpv);
        int d = (a / R) % 8;
        if ((a % R) < G || bm[d]) return 8'hFF;
        return {ref_tbl[nib], ~dpv};
    endfunction

    function automatic logic [3:0] nib_of(logic [31:0] w, int i);
        logic [31:0] s = w >> (4 * i);
        return s[3:0];
    endfunction

    always @(posedge CLK or negedge rst) begin
        if (!rst) begin
            m_active <= 0;
            m_nib    <= '0;
            m_dp     <= 1'b0;
            exp_seg  <= 8'hFF;
            exp_an   <= 8'hFF;
            exp_tick <= 1'b0;
        end else if (!en) begin
            exp_seg  <= 8'hFF;
            exp_an   <= 8'hFF;
            exp_tick <= 1'b0;
        end else begin
            exp_seg  <= model_seg(m_active, blank_mask, m_nib, m_dp);
            exp_an   <= model_an(m_active, blank_mask);
            exp_tick <= (m_active % FR) == FR - 1;
            m_active <= m_active + 1;
            if (m_active % R == R - 1) begin
                m_nib <= nib_of(digits, ((m_active / R) + 1) % 8);
                m_dp  <= dp_mask[((m_active / R) + 1) % 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic step1();
        @(posedge CLK);
        #1;
        cyc++;
        chk("seg_n", seg_n, exp_seg);
        chk("anode_n", anode_n, exp_an);
        chk("digit_idx", digit_idx, 32'((m_active / R) % 8));
        chk("frame_tick", frame_tick, exp_tick);
        chk("anode_onehot", 32'($countones(~anode_n) <= 1), 1);
        if (period_on && frame_tick) begin
            n_ticks++;
            if (last_tick >= 0) chk("tick_period", cyc - last_tick, FR);
            last_tick = cyc;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        int hold_idx;

        digits     = $urandom;
        dp_mask    = 8'($urandom);
        blank_mask = 8'($urandom);
        en         = 1'b1;
        rst        = 1'b0;
        repeat (4) step1();
        chk("rst_seg", seg_n, 8'hFF);
        chk("rst_anode", anode_n, 8'hFF);
        chk("rst_idx", digit_idx, 0);
        chk("rst_tick", frame_tick, 0);

        digits     = 32'h76543210;
        dp_mask    = 8'h00;
        blank_mask = 8'h00;
        rst        = 1'b1;
        step1(); chk("rel_edge1", anode_n, 8'hFF);
        step1(); chk("rel_edge2", anode_n, 8'hFF);
        step1(); chk("rel_edge3_anode", anode_n, 8'h7F);
        chk("rel_edge3_seg", seg_n, 8'h03);

        period_on = 1;
        for (int i = 0; i < 3 * FR; i++) begin
            step1();
            if (anode_n != 8'hFF && (order_q.size() == 0 || order_q[$] != anode_n))
                order_q.push_back(anode_n);
            if (anode_n == 8'hBF) chk("slot1_seg", seg_n, 8'h9F);
            if (anode_n == 8'hFE) chk("slot7_seg", seg_n, 8'h1F);
        end
        period_on = 0;
        chk("tick_count", n_ticks, 3);
        chk("order_len", 32'(order_q.size() >= 16), 1);
        for (int i = 0; i < 16; i++)
            if (i < order_q.size()) chk("anode_order", order_q[i], exp_order[i % 8]);

        dp_mask    = 8'h01;
        blank_mask = 8'h04;
        digits     = 32'hFFFFFF88;
        repeat (FR) step1();
        for (int i = 0; i < FR; i++) begin
            step1();
            if (anode_n == 8'h7F) chk("mask_slot0_seg", seg_n, 8'h00);
            if (anode_n == 8'hEF) chk("mask_slot3_seg", seg_n, 8'h71);
            chk("mask_slot2_dark", anode_n[5], 1);
        end

        digits     = 32'h76543210;
        dp_mask    = 8'h00;
        blank_mask = 8'h00;
        repeat (FR) step1();
        found = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            step1();
            if (anode_n == 8'h7F) begin found = 1; break; end
        end
        chk("wait_slot0", found, 1);
        digits[3:0] = 4'h8;
        for (int i = 0; i < R; i++) begin
            step1();
            if (anode_n != 8'h7F) break;
            chk("midslot_hold", seg_n, 8'h03);
        end
        found = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            step1();
            if (anode_n == 8'h7F) begin
                found = 1;
                chk("next_frame_seg", seg_n, 8'h01);
                break;
            end
        end
        chk("wait_next_slot0", found, 1);

        found = 0;
        for (int i = 0; i < 2 * R; i++) begin
            if (m_active % R == 5) begin found = 1; break; end
            step1();
        end
        chk("wait_cnt5", found, 1);
        hold_idx = (m_active / R) % 8;
        en = 1'b0;
        repeat (20) begin
            step1();
            chk("en_low_anode", anode_n, 8'hFF);
            chk("en_low_seg", seg_n, 8'hFF);
            chk("en_low_idx", digit_idx, hold_idx);
        end
        en = 1'b1;
        step1(); step1();
        chk("resume_same_slot", digit_idx, hold_idx);
        step1();
        chk("resume_next_slot", digit_idx, (hold_idx + 1) % 8);

        found = 0;
        for (int i = 0; i < 2 * R; i++) begin
            step1();
            if (anode_n != 8'hFF) begin found = 1; break; end
        end
        chk("wait_drive", found, 1);
        rst = 1'b0;
        #1;
        chk("async_seg", seg_n, 8'hFF);
        chk("async_anode", anode_n, 8'hFF);
        chk("async_idx", digit_idx, 0);
        repeat (2) step1();
        rst = 1'b1;
        step1(); step1(); step1();
        chk("restart_anode", anode_n, 8'h7F);
        chk("restart_seg", seg_n, 8'h03);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) digits = $urandom;
            if ($urandom_range(0, 31) == 0) dp_mask = 8'($urandom);
            if ($urandom_range(0, 31) == 0) blank_mask = 8'($urandom);
            en = ($urandom_range(0, 9) != 0);
            step1();
        end
        en = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Time-multiplexed display driver downstream of the 8-digit nibble register bank. It consumes the eight stored 4-bit values and scans them onto the shared 8-segment bus and the eight common anodes. It replaces static sel-driven anode selection with an automatic refresh counter, anti-ghosting blanking and per-digit decimal-point and blank masks.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (100 MHz clock gives 1 kHz per digit and 125 Hz per frame); must be >= 2.
GHOST_CYC, 100, blanked cycles at the start of each slot; must satisfy 0 <= GHOST_CYC < REFRESH_DIV.

Ports:
CLK  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
en  input  1  scan enable; when low, counters freeze and outputs are blanked.
digits  input  32  packed nibbles; digit i = digits[4i+3:4i].
dp_mask  input  8  bit i = 1 lights the DP on digit i.
blank_mask  input  8  bit i = 1 forces digit i dark (anode held off).
seg_n  output  8  {A,B,C,D,E,F,G,DP}, active-low.
anode_n  output  8  {a0,a1,...,a7}; digit i is on bit 7-i; active-low.
digit_idx  output  3  digit currently being scanned.
frame_tick  output  1  one-cycle pulse when digit_idx wraps 7->0.

Behaviour:
- Reset (rst low, asynchronous):
  - cnt=0, digit_idx=0, state=BLANK.
  - seg_n=8'hFF, anode_n=8'hFF, frame_tick=0, latched nibble=0, latched dp=0.
- Slot counter cnt counts 0..REFRESH_DIV-1 while en=1.
  - At cnt==REFRESH_DIV-1: cnt wraps to 0 and digit_idx advances mod 8.
  - On the same edge, digits[4*next_idx+:4] and dp_mask[next_idx] are latched.
  - Mid-slot changes to digits or dp_mask therefore appear at that digit's next slot; there is no tearing.
- frame_tick = 1 for exactly the cycle after the edge on which digit_idx goes 7->0.
- State machine:
  - BLANK: active while cnt < GHOST_CYC.
  - DRIVE: active while cnt >= GHOST_CYC.
  - BLANK->DRIVE when cnt reaches GHOST_CYC. DRIVE->BLANK at slot wrap.
  - If GHOST_CYC=0, BLANK is never entered after the first slot wrap.
- Output registers update every edge from the current state, digit_idx and latched data (one-cycle latency):
  - BLANK: seg_n=8'hFF, anode_n=8'hFF.
  - DRIVE with blank_mask[idx]=1: seg_n=8'hFF, anode_n=8'hFF.
  - DRIVE otherwise: anode_n = all ones except bit 7-idx = 0; seg_n = {hex7seg(nibble), ~dp}.
- Hex patterns (A..G, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110.
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111.
  - 8=0000000, 9=0000100, A=0001000, b=1100000.
  - C=0110001, d=1000010, E=0110000, F=0111000.
- At most one anode_n bit is ever 0 on any cycle.
- en low: cnt, digit_idx and state hold. Outputs go 8'hFF on the next edge and frame_tick=0. Resuming continues from the held cnt.
- Reset asserted mid-slot: outputs go 8'hFF immediately (asynchronous). Scan restarts at digit 0, BLANK, after deassertion.

Decomposition:
- Package seg7_pkg:
  - NUM_DIGITS=8.
  - typedef nibble_t (logic [3:0]).
  - typedef seg_t (logic [7:0]).
  - typedef scan_state_t enum {BLANK, DRIVE}.
  - constant SEG_OFF=8'hFF.
  - function or constant table for the 16 hex patterns.
- One combinational sub-module, hex_to_seg7 (nibble_t in, 7-bit active-low A..G out), reused by other display blocks.

Test Plan:
- Bench parameters: REFRESH_DIV=8, GHOST_CYC=2.
- Reset: hold rst=0 with random inputs -> seg_n=8'hFF, anode_n=8'hFF, digit_idx=0, frame_tick=0. Release -> first anode low appears on the output 3 edges after release.
- Scan order: digits=32'h76543210, masks 0 -> anode_n steps 8'h7F, BF, DF, EF, F7, FB, FD, FE. seg_n in slot 0 = 8'h03; slot 1 = 8'h9F; slot 7 = 8'h1F (8'h1F = 0001111 for 7, plus DP off). Each slot has 2 cycles of 8'hFF before drive.
- Frame timing: run 3 frames -> frame_tick pulses exactly every 64 cycles, each one cycle wide. Assert the one-hot/zero invariant on anode_n every cycle.
- Masks: dp_mask=8'h01, blank_mask=8'h04, digits=32'hFFFFFF88 -> slot 0 seg_n=8'h00. Slot 2 anode_n=8'hFF throughout. Slot 3 seg_n=8'h71.
- Mid-slot update: change digit 0 from 0 to 8 while digit 0 is being driven -> seg_n stays 8'h03 for the rest of that slot. Shows 8'h01 on the next frame.
- en and reset mid-operation: drop en for 20 cycles at cnt=5 -> outputs 8'hFF and cnt/idx frozen; resume completes the same slot. Then pulse rst=0 mid-slot -> immediate 8'hFF and restart at digit 0.
